hawk_blk_entry_rmw: RTL and testbench

- Parametrised read-modify-write engine for one table entry (ATT, list, ZsPage metadata word) held inside a single AXI memory block.
- Accepts an entry-granular request, reads the enclosing block, extracts the entry, and returns the old value.
- Optionally merges new bits under a bit mask and writes the block back with byte strobes covering only that entry.
- Sits between the page-table managers and the hawk AXI read/write masters. It generalises fixed 8B/16B entry handling with runtime byteswap and write elision.

---
 rtl/hawk_blk_entry_rmw.sv | 228 ++++++++++++++++++++++
 tb/tb_hawk_blk_entry_rmw.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hawk_blk_entry_rmw.sv
// hawk_blk_entry_rmw: read-modify-write of one table entry inside an AXI block.
// Lookup returns the old entry; RMW merges under mask and writes back strobed.
module hawk_blk_entry_rmw #(
    parameter int ADDR_W      = 64,
    parameter int BLK_BYTES   = 64,
    parameter int ENTRY_BYTES = 8,
    parameter bit ELIDE_EQ    = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [ADDR_W-1:0]        req_addr_i,
    input  logic                     req_write_i,
    input  logic                     req_swap_i,
    input  logic [ENTRY_BYTES*8-1:0] req_wdata_i,
    input  logic [ENTRY_BYTES*8-1:0] req_wmask_i,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [ENTRY_BYTES*8-1:0] resp_rdata_o,
    output logic                     resp_err_o,
    output logic                     resp_elided_o,
    output logic [ADDR_W-1:0]        m_araddr_o,
    output logic [7:0]               m_arlen_o,
    output logic                     m_arvalid_o,
    input  logic                     m_arready_i,
    input  logic [BLK_BYTES*8-1:0]   m_rdata_i,
    input  logic [1:0]               m_rresp_i,
    input  logic                     m_rvalid_i,
    input  logic                     m_rlast_i,
    output logic                     m_rready_o,
    output logic [ADDR_W-1:0]        m_awaddr_o,
    output logic                     m_awvalid_o,
    input  logic                     m_awready_i,
    output logic [BLK_BYTES*8-1:0]   m_wdata_o,
    output logic [BLK_BYTES-1:0]     m_wstrb_o,
    output logic                     m_wvalid_o,
    input  logic                     m_wready_i,
    input  logic [1:0]               m_bresp_i,
    input  logic                     m_bvalid_i,
    output logic                     m_bready_o
);
    localparam int EW    = ENTRY_BYTES * 8;
    localparam int DW    = BLK_BYTES * 8;
    localparam int BOFF  = $clog2(BLK_BYTES);
    localparam int EOFF  = $clog2(ENTRY_BYTES);
    localparam int NENT  = BLK_BYTES / ENTRY_BYTES;
    localparam int IW    = (NENT > 1) ? $clog2(NENT) : 1;
    localparam int LANES = ENTRY_BYTES / 8;

    typedef enum logic [2:0] {IDLE, AR, R, AWW, B, RESP} state_t;

    function automatic logic [EW-1:0] lane_swap(input logic [EW-1:0] v);
        logic [EW-1:0] o;
        o = '0;
        for (int l = 0; l < LANES; l++)
            for (int b = 0; b < 8; b++)
                o[l*64 + b*8 +: 8] = v[l*64 + (7-b)*8 +: 8];
        return o;
    endfunction

    state_t               state_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [IW-1:0]        idx_q;
    logic                 write_q;
    logic                 swap_q;
    logic [EW-1:0]        wdata_q;
    logic [EW-1:0]        wmask_q;
    logic [EW-1:0]        rdata_q;
    logic                 err_q;
    logic                 elided_q;
    logic [DW-1:0]        wblk_q;
    logic [BLK_BYTES-1:0] wstrb_q;
    logic                 req_ready_q;
    logic                 arvalid_q;
    logic                 rready_q;
    logic                 awvalid_q;
    logic                 wvalid_q;
    logic                 bready_q;
    logic                 resp_valid_q;

    logic [EW-1:0]        raw_entry;
    logic [EW-1:0]        old_entry;
    logic [EW-1:0]        new_entry;
    logic [DW-1:0]        merged_blk;
    logic [BLK_BYTES-1:0] slot_strb;
    logic [IW-1:0]        req_idx;
    logic [ADDR_W-1:0]    req_blk;
    logic                 misalign;
    logic                 aw_done;
    logic                 w_done;

    // Merged block is built straight from the R beat so AWW needs no extra cycle.
    always_comb begin
        raw_entry  = m_rdata_i[idx_q*EW +: EW];
        old_entry  = swap_q ? lane_swap(raw_entry) : raw_entry;
        new_entry  = (old_entry & ~wmask_q) | (wdata_q & wmask_q);
        merged_blk = m_rdata_i;
        merged_blk[idx_q*EW +: EW] = swap_q ? lane_swap(new_entry) : new_entry;
        slot_strb  = BLK_BYTES'({ENTRY_BYTES{1'b1}}) << (idx_q*ENTRY_BYTES);
        req_idx    = IW'(req_addr_i[BOFF-1:0] >> EOFF);
        req_blk    = {req_addr_i[ADDR_W-1:BOFF], BOFF'(0)};
        misalign   = |req_addr_i[EOFF-1:0];
        aw_done    = !awvalid_q || m_awready_i;
        w_done     = !wvalid_q || m_wready_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            idx_q        <= '0;
            write_q      <= 1'b0;
            swap_q       <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            elided_q     <= 1'b0;
            wblk_q       <= '0;
            wstrb_q      <= '0;
            req_ready_q  <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid_i && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        addr_q      <= req_blk;
                        idx_q       <= req_idx;
                        write_q     <= req_write_i;
                        swap_q      <= req_swap_i;
                        wdata_q     <= req_wdata_i;
                        wmask_q     <= req_wmask_i;
                        rdata_q     <= '0;
                        elided_q    <= 1'b0;
                        err_q       <= misalign;
                        if (misalign) begin
                            resp_valid_q <= 1'b1;
                            state_q      <= RESP;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= AR;
                        end
                    end
                end
                AR: begin
                    if (m_arready_i) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= R;
                    end
                end
                R: begin
                    if (m_rvalid_i) begin
                        rready_q <= 1'b0;
                        rdata_q  <= old_entry;
                        wblk_q   <= merged_blk;
                        wstrb_q  <= slot_strb;
                        if (m_rresp_i != 2'b00 || !m_rlast_i) begin
                            err_q        <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state_q      <= RESP;
                        end else if (!write_q) begin
                            resp_valid_q <= 1'b1;
                            state_q      <= RESP;
                        end else if (ELIDE_EQ && new_entry == old_entry) begin
                            elided_q     <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state_q      <= RESP;
                        end else begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= AWW;
                        end
                    end
                end
                AWW: begin
                    if (m_awready_i) awvalid_q <= 1'b0;
                    if (m_wready_i)  wvalid_q  <= 1'b0;
                    if (aw_done && w_done) begin
                        bready_q <= 1'b1;
                        state_q  <= B;
                    end
                end
                B: begin
                    if (m_bvalid_i) begin
                        bready_q     <= 1'b0;
                        err_q        <= (m_bresp_i != 2'b00);
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o   = req_ready_q;
    assign resp_valid_o  = resp_valid_q;
    assign resp_rdata_o  = rdata_q;
    assign resp_err_o    = err_q;
    assign resp_elided_o = elided_q;
    assign m_araddr_o    = addr_q;
    assign m_arlen_o     = 8'd0;
    assign m_arvalid_o   = arvalid_q;
    assign m_rready_o    = rready_q;
    assign m_awaddr_o    = addr_q;
    assign m_awvalid_o   = awvalid_q;
    assign m_wdata_o     = wblk_q;
    assign m_wstrb_o     = wstrb_q;
    assign m_wvalid_o    = wvalid_q;
    assign m_bready_o    = bready_q;

endmodule

// File: tb/tb_hawk_blk_entry_rmw.sv
// tb_hawk_blk_entry_rmw: directed checks of the block-entry RMW engine.
// u0 uses 8B entries with elision, u1 uses 16B entries without.
module tb_hawk_blk_entry_rmw;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]   req_valid;
    logic [63:0]  req_addr;
    logic         req_write, req_swap;
    logic [127:0] req_wdata, req_wmask;
    logic         resp_ready;
    logic         m_arready, m_rvalid, m_rlast, m_awready, m_wready, m_bvalid;
    logic [511:0] m_rdata;
    logic [1:0]   m_rresp, m_bresp;

    logic [1:0]   req_ready, resp_valid, resp_err, resp_elided;
    logic [1:0]   arvalid, rready, awvalid, wvalid, bready;
    logic [63:0]  rdata0;
    logic [127:0] rdata1;
    logic [63:0]  araddr0, araddr1, awaddr0, awaddr1;
    logic [7:0]   arlen0, arlen1;
    logic [511:0] wdata0, wdata1;
    logic [63:0]  wstrb0, wstrb1;

    hawk_blk_entry_rmw #(.ENTRY_BYTES(8), .ELIDE_EQ(1'b1)) u0 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_addr_i(req_addr), .req_write_i(req_write), .req_swap_i(req_swap),
        .req_wdata_i(req_wdata[63:0]), .req_wmask_i(req_wmask[63:0]),
        .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready),
        .resp_rdata_o(rdata0), .resp_err_o(resp_err[0]),
        .resp_elided_o(resp_elided[0]),
        .m_araddr_o(araddr0), .m_arlen_o(arlen0), .m_arvalid_o(arvalid[0]),
        .m_arready_i(m_arready), .m_rdata_i(m_rdata), .m_rresp_i(m_rresp),
        .m_rvalid_i(m_rvalid), .m_rlast_i(m_rlast), .m_rready_o(rready[0]),
        .m_awaddr_o(awaddr0), .m_awvalid_o(awvalid[0]), .m_awready_i(m_awready),
        .m_wdata_o(wdata0), .m_wstrb_o(wstrb0), .m_wvalid_o(wvalid[0]),
        .m_wready_i(m_wready), .m_bresp_i(m_bresp), .m_bvalid_i(m_bvalid),
        .m_bready_o(bready[0])
    );

    hawk_blk_entry_rmw #(.ENTRY_BYTES(16), .ELIDE_EQ(1'b0)) u1 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_addr_i(req_addr), .req_write_i(req_write), .req_swap_i(req_swap),
        .req_wdata_i(req_wdata), .req_wmask_i(req_wmask),
        .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready),
        .resp_rdata_o(rdata1), .resp_err_o(resp_err[1]),
        .resp_elided_o(resp_elided[1]),
        .m_araddr_o(araddr1), .m_arlen_o(arlen1), .m_arvalid_o(arvalid[1]),
        .m_arready_i(m_arready), .m_rdata_i(m_rdata), .m_rresp_i(m_rresp),
        .m_rvalid_i(m_rvalid), .m_rlast_i(m_rlast), .m_rready_o(rready[1]),
        .m_awaddr_o(awaddr1), .m_awvalid_o(awvalid[1]), .m_awready_i(m_awready),
        .m_wdata_o(wdata1), .m_wstrb_o(wstrb1), .m_wvalid_o(wvalid[1]),
        .m_wready_i(m_wready), .m_bresp_i(m_bresp), .m_bvalid_i(m_bvalid),
        .m_bready_o(bready[1])
    );

    bit           sel;
    logic         a_req_ready, a_resp_valid, a_err, a_elided;
    logic         a_arvalid, a_rready, a_awvalid, a_wvalid, a_bready;
    logic [127:0] a_rdata;
    logic [63:0]  a_araddr, a_awaddr, a_wstrb;
    logic [7:0]   a_arlen;
    logic [511:0] a_wdata;

    always_comb begin
        a_req_ready  = req_ready[sel];
        a_resp_valid = resp_valid[sel];
        a_err        = resp_err[sel];
        a_elided     = resp_elided[sel];
        a_arvalid    = arvalid[sel];
        a_rready     = rready[sel];
        a_awvalid    = awvalid[sel];
        a_wvalid     = wvalid[sel];
        a_bready     = bready[sel];
        a_rdata      = sel ? rdata1 : {64'h0, rdata0};
        a_araddr     = sel ? araddr1 : araddr0;
        a_awaddr     = sel ? awaddr1 : awaddr0;
        a_arlen      = sel ? arlen1 : arlen0;
        a_wdata      = sel ? wdata1 : wdata0;
        a_wstrb      = sel ? wstrb1 : wstrb0;
    end

    int tests = 0;
    int fails = 0;
    int ar_n, aw_n, aw_cyc, w_cyc, b_n, lat;
    logic [63:0]  ar_addr, aw_addr, w_strb;
    logic [7:0]   o_arlen;
    logic [511:0] w_data;
    logic [127:0] o_rdata;
    logic         o_err, o_elided;
    logic [511:0] base, blk, e;
    logic [17:0]  outs;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input bit s, input logic [63:0] addr, input bit wr, input bit sw,
                       input logic [127:0] wd, input logic [127:0] wm,
                       input logic [1:0] rr, input logic [1:0] br,
                       input int awdly, input bit rst_b);
        int acc;
        int aw_wait;
        bit done;
        sel = s;
        ar_n = 0; aw_n = 0; aw_cyc = 0; w_cyc = 0; b_n = 0; lat = -1;
        ar_addr = '1; aw_addr = '1; w_strb = '0; w_data = '0; o_arlen = '1;
        o_rdata = '1; o_err = 1'bx; o_elided = 1'bx;
        acc = -1; aw_wait = 0; done = 1'b0;
        req_addr = addr; req_write = wr; req_swap = sw;
        req_wdata = wd; req_wmask = wm;
        req_valid = 2'b00;
        req_valid[s] = 1'b1;
        for (int c = 0; c < 60 && !done; c++) begin
            if (req_valid[s] && a_req_ready) acc = c;
            m_arready = 1'b1;
            if (a_arvalid) begin
                ar_n++; ar_addr = a_araddr; o_arlen = a_arlen;
            end
            m_rvalid = a_rready; m_rresp = rr; m_rlast = 1'b1;
            m_awready = a_awvalid && (aw_wait >= awdly);
            if (a_awvalid) begin
                aw_cyc++; aw_wait++;
                if (m_awready) begin aw_n++; aw_addr = a_awaddr; end
            end
            m_wready = 1'b1;
            if (a_wvalid) begin
                w_cyc++; w_data = a_wdata; w_strb = a_wstrb;
            end
            m_bresp = br;
            m_bvalid = a_bready && !rst_b;
            if (m_bvalid) b_n++;
            if (a_bready && rst_b) begin rst_n = 1'b0; done = 1'b1; end
            resp_ready = 1'b1;
            if (a_resp_valid) begin
                o_rdata = a_rdata; o_err = a_err; o_elided = a_elided;
                lat = c - acc; done = 1'b1;
            end
            @(negedge clk);
            if (acc >= 0) req_valid = 2'b00;
        end
        req_valid = 2'b00; resp_ready = 1'b0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_awready = 1'b0;
        m_wready = 1'b0; m_bvalid = 1'b0;
        chk("finished", {511'h0, done}, 512'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; sel = 1'b0; req_valid = 2'b00;
        req_addr = '0; req_write = 1'b0; req_swap = 1'b0;
        req_wdata = '0; req_wmask = '0; resp_ready = 1'b0;
        m_arready = 1'b0; m_rdata = '0; m_rresp = 2'b00; m_rvalid = 1'b0;
        m_rlast = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
        m_bresp = 2'b00; m_bvalid = 1'b0;
        base = {8{64'hDEAD_BEEF_0BAD_F00D}};
        repeat (3) @(negedge clk);
        outs = {req_ready, resp_valid, arvalid, rready, awvalid,
                wvalid, bready, resp_err, resp_elided};
        chk("reset_outs", {494'h0, outs}, 512'h0);
        chk("reset_rdata", {384'h0, rdata0, 64'h0}, 512'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {510'h0, req_ready}, 512'h3);

        blk = base; blk[192 +: 64] = 64'h1122_3344_5566_7788; m_rdata = blk;
        run(0, 64'h1000_0018, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0);
        chk("lk_araddr", {448'h0, ar_addr}, {448'h0, 64'h1000_0000});
        chk("lk_arlen", {504'h0, o_arlen}, 512'h0);
        chk("lk_rdata", {384'h0, o_rdata}, {448'h0, 64'h1122_3344_5566_7788});
        chk("lk_err", {511'h0, o_err}, 512'h0);
        chk("lk_no_aw", 512'(aw_n + w_cyc), 512'h0);
        chk("lk_lat", 512'(lat), 512'd3);
        chk("b2b_ready", {511'h0, a_req_ready}, 512'h1);

        run(0, 64'h1000_0018, 0, 1, 0, 0, 2'd0, 2'd0, 0, 0);
        chk("lk_swap", {384'h0, o_rdata}, {448'h0, 64'h8877_6655_4433_2211});

        blk = base; blk[64 +: 64] = 64'h0000_0000_0000_00F0; m_rdata = blk;
        run(0, 64'h2000_0008, 1, 0, 128'h0F, 128'hFF, 2'd0, 2'd0, 0, 0);
        e = blk; e[64 +: 64] = 64'h0000_0000_0000_000F;
        chk("rmw_rdata", {384'h0, o_rdata}, {448'h0, 64'hF0});
        chk("rmw_wstrb", {448'h0, w_strb}, {448'h0, 64'h0000_0000_0000_FF00});
        chk("rmw_wdata", w_data, e);
        chk("rmw_awaddr", {448'h0, aw_addr}, {448'h0, 64'h2000_0000});
        chk("rmw_b", 512'(b_n), 512'd1);
        chk("rmw_lat", 512'(lat), 512'd5);
        chk("rmw_flags", {510'h0, o_err, o_elided}, 512'h0);

        run(0, 64'h2000_0008, 1, 0, 128'h1234, 128'h0, 2'd0, 2'd0, 0, 0);
        chk("elide_flag", {511'h0, o_elided}, 512'h1);
        chk("elide_no_aw", 512'(aw_n + w_cyc), 512'h0);
        chk("elide_rdata", {384'h0, o_rdata}, {448'h0, 64'hF0});
        chk("elide_lat", 512'(lat), 512'd3);

        blk = base; blk[192 +: 64] = 64'h1122_3344_5566_7788; m_rdata = blk;
        run(0, 64'h18, 1, 1, 128'hAA, 128'hFF, 2'd0, 2'd0, 0, 0);
        e = blk; e[192 +: 64] = 64'hAA22_3344_5566_7788;
        chk("swrmw_rdata", {384'h0, o_rdata}, {448'h0, 64'h8877_6655_4433_2211});
        chk("swrmw_wdata", w_data, e);
        chk("swrmw_wstrb", {448'h0, w_strb}, {448'h0, 64'h0000_0000_FF00_0000});

        run(0, 64'h2000_0004, 1, 0, 128'h0F, 128'hFF, 2'd0, 2'd0, 0, 0);
        chk("mis_err", {511'h0, o_err}, 512'h1);
        chk("mis_no_ar", 512'(ar_n), 512'h0);
        chk("mis_rdata", {384'h0, o_rdata}, 512'h0);

        blk = base; blk[64 +: 64] = 64'h0000_0000_0000_00F0; m_rdata = blk;
        run(0, 64'h08, 1, 0, 128'h0F, 128'hFF, 2'd2, 2'd0, 0, 0);
        chk("rresp_err", {511'h0, o_err}, 512'h1);
        chk("rresp_no_aw", 512'(aw_n + w_cyc + b_n), 512'h0);

        run(0, 64'h08, 1, 0, 128'h0F, 128'hFF, 2'd0, 2'd2, 0, 0);
        chk("bresp_err", {511'h0, o_err}, 512'h1);
        chk("bresp_wrote", 512'(aw_n + b_n), 512'd2);

        blk = base;
        blk[128 +: 128] = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
        m_rdata = blk;
        run(1, 64'h10, 1, 0, 128'h5555, 128'h0, 2'd0, 2'd0, 0, 0);
        chk("noel_aw", 512'(aw_n), 512'd1);
        chk("noel_wdata", w_data, blk);
        chk("noel_wstrb", {448'h0, w_strb}, {448'h0, 64'h0000_0000_FFFF_0000});
        chk("noel_flag", {511'h0, o_elided}, 512'h0);

        blk = base;
        blk[384 +: 128] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        m_rdata = blk;
        run(1, 64'h30, 1, 0, 128'h0,
            128'h0000_0000_0000_FFFF_0000_0000_0000_0000, 2'd0, 2'd0, 4, 0);
        e = blk; e[384 +: 128] = 128'h0123_4567_89AB_0000_FEDC_BA98_7654_3210;
        chk("bp_wcyc", 512'(w_cyc), 512'd1);
        chk("bp_awcyc", 512'(aw_cyc), 512'd5);
        chk("bp_one_b", 512'(b_n), 512'd1);
        chk("bp_wstrb", {448'h0, w_strb}, {448'h0, 64'hFFFF_0000_0000_0000});
        chk("bp_wdata", w_data, e);
        chk("bp_rdata", {384'h0, o_rdata},
            {384'h0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210});

        run(1, 64'h30, 0, 1, 0, 0, 2'd0, 2'd0, 0, 0);
        chk("lk16_swap", {384'h0, o_rdata},
            {384'h0, 128'hEFCD_AB89_6745_2301_1032_5476_98BA_DCFE});

        blk = base; blk[64 +: 64] = 64'h0000_0000_0000_00F0; m_rdata = blk;
        run(0, 64'h08, 1, 0, 128'h0F, 128'hFF, 2'd0, 2'd0, 0, 1);
        outs = {req_ready, resp_valid, arvalid, rready, awvalid,
                wvalid, bready, resp_err, resp_elided};
        chk("rstB_outs", {494'h0, outs}, 512'h0);
        rst_n = 1'b1;
        ar_n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (arvalid != 2'b00 || awvalid != 2'b00 || wvalid != 2'b00) ar_n++;
        end
        chk("rstB_no_replay", 512'(ar_n), 512'h0);
        chk("rstB_ready", {510'h0, req_ready}, 512'h3);
        blk = base; blk[192 +: 64] = 64'h1122_3344_5566_7788; m_rdata = blk;
        run(0, 64'h18, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0);
        chk("rstB_after", {384'h0, o_rdata}, {448'h0, 64'h1122_3344_5566_7788});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
